// File: rtl/turn_signal_command_if.sv
// Button-to-command bundle between the board pins and the turn-signal front end.
// The master side owns the raw buttons; the slave side (the front end) drives the
// level commands consumed by the blink logic.
interface turn_signal_command_if;
    logic btn_left;
    logic btn_right;
    logic btn_hazard;
    logic sw_left;
    logic sw_right;
    logic sw_hazard;

    modport master (
        output btn_left,
        output btn_right,
        output btn_hazard,
        input  sw_left,
        input  sw_right,
        input  sw_hazard
    );

    modport slave (
        input  btn_left,
        input  btn_right,
        input  btn_hazard,
        output sw_left,
        output sw_right,
        output sw_hazard
    );
endinterface

// File: rtl/turn_signal_command.sv
// Turn-signal driver-input front end: synchronizes and debounces the left, right
// and hazard buttons, then turns press/release events into level commands with
// toggle/cancel, lane-change comfort auto-off and long-press latching.
module turn_signal_command #(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_PRESS_CYC = 25_000_000,
    parameter int BLINK_CYC      = 50_000_000,
    parameter int LANE_BLINKS    = 3
) (
    input  logic clk,
    input  logic rst,
    turn_signal_command_if.slave bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC) + 1;
    localparam int CNT_W = $clog2(LANE_BLINKS * BLINK_CYC) + 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_PRESS_CYC);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(LANE_BLINKS * BLINK_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, COMFORT, LATCHED} state_t;
    typedef enum logic {DIR_L, DIR_R} dir_t;

    // Bit 0 = left, bit 1 = right, bit 2 = hazard throughout.
    logic [2:0] btn_raw;
    logic [2:0] deb_lvl;
    logic [2:0] deb_prev;
    logic [2:0] press;
    logic [1:0] rel_lr;

    assign btn_raw = {bus.btn_hazard, bus.btn_right, bus.btn_left};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic            deb_d_reg;
            logic [DB_W-1:0] cnt_reg;

            // Two-flop synchronizer, then accept a new level only after it has been stable long enough
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_lvl[gi]  = deb_reg;
            assign deb_prev[gi] = deb_d_reg;
        end
    endgenerate

    // Events are one-cycle pulses on the debounced edges.
    assign press  = deb_lvl & ~deb_prev;
    assign rel_lr = ~deb_lvl[1:0] & deb_prev[1:0];

    state_t           state_reg, state_next;
    dir_t             dir_reg, dir_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             haz_reg, haz_next;
    logic             sw_left_reg, sw_right_reg;
    dir_t             press_dir;
    logic             held_rel;

    assign press_dir = press[1] ? DIR_R : DIR_L;
    assign held_rel  = (dir_reg == DIR_R) ? rel_lr[1] : rel_lr[0];

    // Direction FSM next state; press events take priority over timeouts
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
        haz_next   = haz_reg ^ press[2];
        if (state_reg == IDLE) begin
            cnt_next = '0;
            if (press[0] ^ press[1]) begin
                state_next = PRESSED;
                dir_next   = press_dir;
            end
        end else if (press[0] && press[1]) begin
            // Ambiguous simultaneous presses are ignored; only the timer keeps running.
            state_next = state_reg;
        end else if (press[0] || press[1]) begin
            cnt_next = '0;
            if (press_dir == dir_reg) begin
                state_next = IDLE;
            end else begin
                state_next = PRESSED;
                dir_next   = press_dir;
            end
        end else if (state_reg == PRESSED) begin
            if (held_rel && (cnt_reg < LONG_LIM)) begin
                state_next = COMFORT;
            end else if (cnt_reg >= LONG_LIM) begin
                state_next = LATCHED;
            end
        end else if (state_reg == COMFORT) begin
            if (cnt_reg >= LANE_LAST) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    // State, timer and registered commands derived from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            dir_reg      <= DIR_L;
            cnt_reg      <= '0;
            haz_reg      <= 1'b0;
            sw_left_reg  <= 1'b0;
            sw_right_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            cnt_reg      <= cnt_next;
            haz_reg      <= haz_next;
            sw_left_reg  <= (state_next != IDLE) && (dir_next == DIR_L);
            sw_right_reg <= (state_next != IDLE) && (dir_next == DIR_R);
        end
    end

    assign bus.sw_left   = sw_left_reg;
    assign bus.sw_right  = sw_right_reg;
    assign bus.sw_hazard = haz_reg;
endmodule

// File: tb/tb_turn_signal_command.sv
// Bench for turn_signal_command: directed vector table, two exact-timing
// sequences, then random button activity checked every cycle against a
// behavioural model of the button/command rules.
module tb_turn_signal_command;
    localparam int D  = 4;
    localparam int LP = 10;
    localparam int BL = 20;
    localparam int LB = 3;

    localparam int M_OFF  = 0;
    localparam int M_HELD = 1;
    localparam int M_LANE = 2;
    localparam int M_LOCK = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    turn_signal_command_if bus_if ();

    turn_signal_command #(
        .DEBOUNCE_CYC  (D),
        .LONG_PRESS_CYC(LP),
        .BLINK_CYC     (BL),
        .LANE_BLINKS   (LB)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_p1  [3];
    bit m_p2  [3];
    bit m_deb [3];
    bit m_win [3][D];
    bit ev_press [3];
    bit ev_rel   [3];
    int m_mode;
    int m_side;
    int m_age;
    bit m_haz;

    task automatic model_step(input bit rn, input bit [2:0] raw);
        bit pl, pr, all_diff, s;
        int newside;
        if (!rn) begin
            for (int b = 0; b < 3; b++) begin
                m_p1[b] = 0; m_p2[b] = 0; m_deb[b] = 0;
                ev_press[b] = 0; ev_rel[b] = 0;
                for (int i = 0; i < D; i++) m_win[b][i] = 0;
            end
            m_mode = M_OFF; m_side = 0; m_age = 0; m_haz = 0;
        end else begin
            // Commands react to the events found on the previous cycle.
            pl = ev_press[0];
            pr = ev_press[1];
            if (ev_press[2]) m_haz = !m_haz;
            if (m_mode == M_OFF) begin
                if (pl != pr) begin
                    m_mode = M_HELD; m_side = pr ? 1 : 0; m_age = 0;
                end
            end else if (pl && pr) begin
                m_age++;
            end else if (pl || pr) begin
                newside = pr ? 1 : 0;
                if (newside == m_side) m_mode = M_OFF;
                else begin m_side = newside; m_mode = M_HELD; end
                m_age = 0;
            end else begin
                if (m_mode == M_HELD) begin
                    if (ev_rel[m_side] && m_age < LP) m_mode = M_LANE;
                    else if (m_age >= LP) m_mode = M_LOCK;
                end else if (m_mode == M_LANE && m_age + 1 >= LB * BL) begin
                    m_mode = M_OFF;
                end
                m_age++;
            end
            // A level is accepted once the last D synchronized samples all disagree with it.
            for (int b = 0; b < 3; b++) begin
                s = m_p2[b];
                for (int i = D - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
                m_win[b][0] = s;
                all_diff = 1;
                for (int i = 0; i < D; i++) if (m_win[b][i] == m_deb[b]) all_diff = 0;
                ev_press[b] = 0; ev_rel[b] = 0;
                if (all_diff) begin
                    m_deb[b] = s;
                    ev_press[b] = s;
                    ev_rel[b] = !s;
                end
                m_p2[b] = m_p1[b];
                m_p1[b] = raw[b];
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic set_btn(input bit l, input bit r, input bit h);
        bus_if.btn_left   = l;
        bus_if.btn_right  = r;
        bus_if.btn_hazard = h;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        bit [2:0] exp;
        bit [2:0] got;
        @(posedge clk);
        model_step(rst_n, {bus_if.btn_hazard, bus_if.btn_right, bus_if.btn_left});
        #1;
        cyc++;
        exp = {m_mode != M_OFF && m_side == 0, m_mode != M_OFF && m_side == 1, m_haz};
        got = {bus_if.sw_left, bus_if.sw_right, bus_if.sw_hazard};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model cycle=%0d got lrh=%b expected lrh=%b", cyc, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int cyc;
        bit rn, l, r, h;
        bit el, er, eh;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input bit rn, input bit l, input bit r, input bit h,
                       input bit el, input bit er, input bit eh);
        vec_t v;
        v.cyc = n; v.rn = rn; v.l = l; v.r = r; v.h = h;
        v.el = el; v.er = er; v.eh = eh;
        vecs.push_back(v);
    endtask

    int  rise, fall, lfall, rrise;
    bit  lvl[3];
    int  hold[3];
    bit [2:0] got3;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0;
        set_btn(0, 0, 0);

        // reset state
        add(3, 0, 0,0,0, 0,0,0);
        // bounce rejection
        for (int i = 0; i < 10; i++) add(2, 1, (i % 2 == 0), 0, 0, 0,0,0);
        add(10, 1, 0,0,0, 0,0,0);
        // latched, then cancel with a second press
        add(30, 1, 1,0,0, 1,0,0);
        add(300,1, 0,0,0, 1,0,0);
        add(6,  1, 1,0,0, 1,0,0);
        add(1,  1, 1,0,0, 0,0,0);
        add(1,  1, 1,0,0, 0,0,0);
        add(20, 1, 0,0,0, 0,0,0);
        // switch-over from latched left to right, right comfort expiry
        add(30, 1, 1,0,0, 1,0,0);
        add(10, 1, 0,0,0, 1,0,0);
        add(6,  1, 0,1,0, 1,0,0);
        add(1,  1, 0,1,0, 0,1,0);
        add(1,  1, 0,1,0, 0,1,0);
        add(70, 1, 0,0,0, 0,0,0);
        // simultaneous left+right from idle
        add(20, 1, 1,1,0, 0,0,0);
        add(20, 1, 0,0,0, 0,0,0);
        // hazard independent of left comfort; left off exactly 60 cycles after rising
        add(8,  1, 1,0,0, 1,0,0);
        add(8,  1, 0,0,1, 1,0,1);
        add(20, 1, 0,0,0, 1,0,1);
        add(20, 1, 0,0,0, 1,0,1);
        add(10, 1, 0,0,0, 1,0,1);
        add(1,  1, 0,0,0, 0,0,1);
        add(8,  1, 0,0,1, 0,0,0);
        add(20, 1, 0,0,0, 0,0,0);
        // reset mid-operation
        add(8,  1, 1,0,0, 1,0,0);
        add(8,  1, 0,0,1, 1,0,1);
        add(10, 1, 0,0,0, 1,0,1);
        add(1,  0, 0,0,0, 0,0,0);
        add(100,1, 0,0,0, 0,0,0);
        // button held through reset release
        add(3,  0, 1,0,0, 0,0,0);
        add(6,  1, 1,0,0, 0,0,0);
        add(1,  1, 1,0,0, 1,0,0);
        add(1,  1, 1,0,0, 1,0,0);
        add(70, 1, 0,0,0, 0,0,0);
        // right comfort cancelled by a second right press
        add(7,  1, 0,1,0, 0,1,0);
        add(1,  1, 0,1,0, 0,1,0);
        add(10, 1, 0,0,0, 0,1,0);
        add(6,  1, 0,1,0, 0,1,0);
        add(1,  1, 0,1,0, 0,0,0);
        add(20, 1, 0,0,0, 0,0,0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rn;
            set_btn(vecs[i].l, vecs[i].r, vecs[i].h);
            ticks(vecs[i].cyc);
            got3 = {bus_if.sw_left, bus_if.sw_right, bus_if.sw_hazard};
            chk($sformatf("vec[%0d]", i), int'(got3), int'({vecs[i].el, vecs[i].er, vecs[i].eh}));
        end

        // comfort: rise 7 cycles after the raw edge, high for exactly 60 cycles
        rst_n = 1'b1;
        rise = -1; fall = -1;
        set_btn(1, 0, 0);
        for (int k = 1; k <= 120; k++) begin
            if (k == 9) set_btn(0, 0, 0);
            tick();
            if (bus_if.sw_left && rise < 0) rise = k;
            if (!bus_if.sw_left && rise >= 0 && fall < 0) fall = k;
        end
        chk("comfort_rise", rise, 7);
        chk("comfort_width", fall - rise, 60);

        // switch-over: left drops and right rises on the same edge
        set_btn(1, 0, 0);
        ticks(30);
        set_btn(0, 0, 0);
        ticks(20);
        chk("latched_left", int'(bus_if.sw_left), 1);
        lfall = -1; rrise = -1;
        set_btn(0, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) set_btn(0, 0, 0);
            tick();
            if (!bus_if.sw_left && lfall < 0) lfall = k;
            if (bus_if.sw_right && rrise < 0) rrise = k;
        end
        chk("switch_left_fall", lfall, 7);
        chk("switch_right_rise", rrise, 7);
        ticks(80);

        // random activity checked by the model each cycle
        for (int b = 0; b < 3; b++) begin lvl[b] = 0; hold[b] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 9) < 4) hold[b] = $urandom_range(1, 3);
                    else hold[b] = $urandom_range(4, 70);
                end
                hold[b]--;
            end
            rst_n = ($urandom_range(0, 599) != 0);
            set_btn(lvl[0], lvl[1], lvl[2]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
